// File: rtl/mem_data_responder.sv
// Data-memory responder: single-cycle writes, reads answered after WAIT_CYCLES
// extra clocks through a busy/outValid handshake, with a sticky address-error flag.
module mem_data_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] readAddress,
    input  logic        readEnabled,
    input  logic [31:0] writeAddress,
    input  logic [31:0] data,
    input  logic        writeEnabled,
    output logic [31:0] out,
    output logic        outValid,
    output logic        busy,
    output logic        addrErr
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_idx_q;
    logic              rd_oor_q;
    logic [31:0]       out_q;
    logic              addr_err_q;

    logic [ADDR_W-1:0] rd_idx, wr_idx, load_idx;
    logic              rd_oor, wr_oor, rd_mis, wr_mis, load_oor;
    logic              accept, load_resp, wr_en, wr_hit;

    assign rd_idx = readAddress[ADDR_W+1:2];
    assign wr_idx = writeAddress[ADDR_W+1:2];
    assign rd_oor = |readAddress[31:ADDR_W+2];
    assign wr_oor = |writeAddress[31:ADDR_W+2];
    assign rd_mis = |readAddress[1:0];
    assign wr_mis = |writeAddress[1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        load_resp = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (readEnabled) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = S_RESP;
                        load_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d   = S_RESP;
                    load_resp = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the response loads at the acceptance edge itself,
    // so the live request address is used instead of the captured one.
    assign load_idx = accept ? rd_idx : rd_idx_q;
    assign load_oor = accept ? rd_oor : rd_oor_q;
    assign wr_en    = writeEnabled && !wr_oor && reset;
    assign wr_hit   = wr_en && (wr_idx == load_idx);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rd_idx_q   <= '0;
            rd_oor_q   <= 1'b0;
            out_q      <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rd_idx_q <= rd_idx;
                rd_oor_q <= rd_oor;
            end
            // Write-first: a same-word write at the loading edge wins over storage.
            if (load_resp) begin
                out_q <= load_oor ? 32'd0 : (wr_hit ? data : mem[load_idx]);
            end
            if ((writeEnabled && (wr_mis || wr_oor)) || (accept && (rd_mis || rd_oor))) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign out      = out_q;
    assign outValid = (state_q == S_RESP);
    assign busy     = (state_q == S_WAIT);
    assign addrErr  = addr_err_q;

endmodule

// File: tb/tb_mem_data_responder.sv
// Directed bench: four responders (WAIT_CYCLES 0..3) share one stimulus stream;
// each scenario checks the instance whose wait count it targets.
module tb_mem_data_responder;

    logic        clk;
    logic        reset;
    logic [31:0] readAddress, writeAddress, data;
    logic        readEnabled, writeEnabled;
    logic [31:0] out_w [4];
    logic [3:0]  valid_w, busy_w, err_w;

    int n_checks = 0;
    int n_fail   = 0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            mem_data_responder #(.ADDR_W(8), .WAIT_CYCLES(gi)) u_dut (
                .clk         (clk),
                .reset       (reset),
                .readAddress (readAddress),
                .readEnabled (readEnabled),
                .writeAddress(writeAddress),
                .data        (data),
                .writeEnabled(writeEnabled),
                .out         (out_w[gi]),
                .outValid    (valid_w[gi]),
                .busy        (busy_w[gi]),
                .addrErr     (err_w[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        re;
        logic [31:0] raddr;
        logic        exp_valid;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs [9];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                         input logic re, input logic [31:0] ra);
        writeEnabled = we;
        writeAddress = wa;
        data         = wd;
        readEnabled  = re;
        readAddress  = ra;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        repeat (n) cyc();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Clocks until the selected instance raises outValid; lat is the number of
    // edges taken. Expiry of the budget counts as a failed comparison.
    task automatic wait_valid(input int idx, input int max_cyc, output int lat);
        lat = 0;
        while (1) begin
            cyc();
            lat++;
            if (valid_w[idx]) break;
            if (lat >= max_cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL wait_valid[%0d]: no outValid within %0d cycles", idx, max_cyc);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int         lat;
        logic [5:0] exp_v, exp_b;

        vecs[0] = '{1'b1, 32'h000, 32'hA000_0000, 1'b0, 32'h000, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 32'h004, 32'hA000_0004, 1'b0, 32'h000, 1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h008, 32'hA000_0008, 1'b0, 32'h000, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h000, 32'h0000_0000, 1'b1, 32'h000, 1'b1, 32'hA000_0000};
        vecs[4] = '{1'b0, 32'h000, 32'h0000_0000, 1'b1, 32'h004, 1'b1, 32'hA000_0004};
        vecs[5] = '{1'b0, 32'h000, 32'h0000_0000, 1'b1, 32'h008, 1'b1, 32'hA000_0008};
        vecs[6] = '{1'b0, 32'h000, 32'h0000_0000, 1'b0, 32'h000, 1'b0, 32'hA000_0008};
        vecs[7] = '{1'b1, 32'h00C, 32'h5A5A_5A5A, 1'b1, 32'h00C, 1'b1, 32'h5A5A_5A5A};
        vecs[8] = '{1'b0, 32'h000, 32'h0000_0000, 1'b0, 32'h000, 1'b0, 32'h5A5A_5A5A};

        // Reset sequencing
        reset = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_out[%0d]", i),   out_w[i],   32'd0);
            chk($sformatf("rst_valid[%0d]", i), valid_w[i], 32'd0);
            chk($sformatf("rst_busy[%0d]", i),  busy_w[i],  32'd0);
            chk($sformatf("rst_err[%0d]", i),   err_w[i],   32'd0);
        end
        $display("txn reset released");

        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'd0);
        cyc();
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h10);
        cyc();
        chk("w1_busy_after_accept",  busy_w[1],  32'd1);
        chk("w1_valid_after_accept", valid_w[1], 32'd0);
        idle(1);
        chk("w1_valid_resp", valid_w[1], 32'd1);
        chk("w1_out_resp",   out_w[1],   32'hDEAD_BEEF);
        chk("w1_busy_resp",  busy_w[1],  32'd0);
        cyc();
        chk("w1_valid_pulse_end", valid_w[1], 32'd0);
        chk("w1_out_held",        out_w[1],   32'hDEAD_BEEF);
        $display("txn read 0x10 on wait=1 done");
        idle(5);

        // Table-driven zero-wait traffic: back-to-back reads and same-cycle write/read
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].re, vecs[v].raddr);
            cyc();
            chk($sformatf("vec%0d_valid", v), valid_w[0], 32'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_out", v),   out_w[0],   vecs[v].exp_out);
            chk($sformatf("vec%0d_busy", v),  busy_w[0],  32'd0);
            $display("txn vec %0d we=%0b wa=%08h re=%0b ra=%08h -> valid=%0b out=%08h",
                     v, vecs[v].we, vecs[v].waddr, vecs[v].re, vecs[v].raddr, valid_w[0], out_w[0]);
        end
        idle(6);

        // Write-first forwarding on wait=2
        drive(1'b1, 32'h20, 32'h1111_1111, 1'b0, 32'd0);
        cyc();
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h20);
        cyc();
        chk("w2_busy_accept", busy_w[2], 32'd1);
        idle(1);
        chk("w2_busy_last_wait",  busy_w[2],  32'd1);
        chk("w2_valid_last_wait", valid_w[2], 32'd0);
        drive(1'b1, 32'h20, 32'h2222_2222, 1'b0, 32'd0);
        cyc();
        chk("w2_fwd_valid", valid_w[2], 32'd1);
        chk("w2_fwd_out",   out_w[2],   32'h2222_2222);
        $display("txn forwarding read 0x20 -> %08h", out_w[2]);
        idle(6);

        // Held readEnabled on wait=2: requests during busy are dropped
        exp_v = 6'b100100;
        exp_b = 6'b011011;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b1, 32'(k * 4));
            cyc();
            chk($sformatf("hold%0d_valid", k), valid_w[2], 32'(exp_v[k]));
            chk($sformatf("hold%0d_busy", k),  busy_w[2],  32'(exp_b[k]));
            if (k == 2) chk("hold2_out", out_w[2], 32'hA000_0000);
            if (k == 5) chk("hold5_out", out_w[2], 32'h5A5A_5A5A);
            $display("txn held read %0d ra=%08h valid=%0b busy=%0b", k, k * 4, valid_w[2], busy_w[2]);
        end
        idle(1);
        chk("hold_after_valid", valid_w[2], 32'd0);
        chk("hold_after_busy",  busy_w[2],  32'd0);
        cyc();
        chk("hold_no_extra", valid_w[2], 32'd0);
        idle(6);

        // Address errors on wait=0
        chk("err_clear_before", err_w[0], 32'd0);
        drive(1'b1, 32'h3FC, 32'hAAAA_5555, 1'b0, 32'd0);
        cyc();
        chk("err_clear_after_top_write", err_w[0], 32'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h3FE);
        cyc();
        chk("mis_read_valid", valid_w[0], 32'd1);
        chk("mis_read_out",   out_w[0],   32'hAAAA_5555);
        chk("mis_read_err",   err_w[0],   32'd1);
        drive(1'b1, 32'h400, 32'hBBBB_BBBB, 1'b0, 32'd0);
        cyc();
        chk("oor_write_err", err_w[0], 32'd1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h400);
        cyc();
        chk("oor_read_valid", valid_w[0], 32'd1);
        chk("oor_read_out",   out_w[0],   32'd0);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h000);
        cyc();
        chk("oor_write_discarded", out_w[0], 32'hA000_0000);
        idle(1);
        chk("err_sticky", err_w[0], 32'd1);
        $display("txn address error sequence done err=%0b", err_w[0]);
        idle(6);

        // Asynchronous reset in the second WAIT cycle of wait=3
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h10);
        cyc();
        chk("w3_busy_accept", busy_w[3], 32'd1);
        idle(1);
        reset = 1'b0;
        #1;
        chk("arst_busy",  busy_w[3],  32'd0);
        chk("arst_valid", valid_w[3], 32'd0);
        chk("arst_out",   out_w[3],   32'd0);
        chk("arst_err",   err_w[0],   32'd0);
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk($sformatf("arst_no_resp%0d", k), valid_w[3], 32'd0);
        end
        $display("txn reset during wait done");

        // Write during busy on wait=3
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h10);
        cyc();
        chk("busy_write_busy0", busy_w[3], 32'd1);
        drive(1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'd0);
        cyc();
        chk("busy_write_busy1", busy_w[3], 32'd1);
        idle(0);
        wait_valid(3, 8, lat);
        chk("w3_latency_rest", 32'(lat), 32'd2);
        chk("w3_out_persist",  out_w[3], 32'hDEAD_BEEF);
        idle(1);
        drive(1'b0, 32'd0, 32'd0, 1'b1, 32'h40);
        cyc();
        idle(0);
        wait_valid(3, 8, lat);
        chk("w3_latency_full",   32'(lat), 32'd3);
        chk("busy_write_landed", out_w[3], 32'h1234_5678);
        $display("txn read 0x40 after busy write -> %08h", out_w[3]);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_data_responder.md
Name: mem_data_responder

Overview:
- Memory-side responder for the core's data-memory port; it services the requests the pipeline issues.
- Accepts single-cycle word writes from the write stage on a dedicated write port.
- Serves reads from the execute stage with a configurable wait-state count and a busy/valid handshake.
- Replaces the fixed-latency data memory so the core can be run against slower memory timing.

Parameters:
- ADDR_W, 8, word-index width; storage depth is 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 1, extra cycles a read waits before responding. Legal range 0..15.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- reset, in, 1, asynchronous active-low reset.
- readAddress, in, 32, byte address of the read request.
- readEnabled, in, 1, read request; accepted when busy=0.
- writeAddress, in, 32, byte address of the write.
- data, in, 32, write data.
- writeEnabled, in, 1, write strobe; a write is never stalled.
- out, out, 32, read data; held until the next response.
- outValid, out, 1, one-cycle pulse marking a new out value.
- busy, out, 1, high while a read is waiting; read requests are ignored while busy=1.
- addrErr, out, 1, sticky flag for a misaligned or out-of-range access; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - out=0, outValid=0, busy=0, addrErr=0, FSM=IDLE, wait counter=0.
  - Any pending read is dropped.
  - A write strobed while reset=0 is ignored.
  - Storage contents are not cleared and are undefined after power-up.
- Addressing:
  - Word index = addr[ADDR_W+1:2].
  - addr[1:0]!=0 sets addrErr; the access still proceeds on the truncated word.
  - addr[31:ADDR_W+2]!=0 (out of range) sets addrErr; such a write is discarded and such a read returns 0.
- Writes: when writeEnabled=1, data is stored at the rising edge. This happens in every FSM state, independent of busy.
- FSM states: IDLE, WAIT, RESP.
  - IDLE/RESP, readEnabled=1, WAIT_CYCLES=0: capture the address and go to RESP.
  - IDLE/RESP, readEnabled=1, WAIT_CYCLES>0: capture the address, load counter=WAIT_CYCLES-1, go to WAIT.
  - IDLE/RESP, readEnabled=0: go to IDLE.
  - WAIT, counter!=0: decrement the counter.
  - WAIT, counter=0: go to RESP.
  - WAIT: readEnabled is ignored (not queued).
- Response timing:
  - A read accepted at edge E produces out and outValid=1 in the cycle after edge E+WAIT_CYCLES.
  - Latency is therefore WAIT_CYCLES+1 clocks.
  - outValid is 1 only in RESP.
- busy = (FSM==WAIT), driven from a register with no combinational path from the inputs.
  - With WAIT_CYCLES=0, busy never asserts and back-to-back reads give one response per cycle.
- Response data is sampled at the edge entering RESP, write-first:
  - A write to the same word at that same edge returns the new data.
  - A write at an earlier edge during WAIT is also visible.
  - A write at the acceptance edge E is visible as well.
- Read and write to the same word in the same cycle with WAIT_CYCLES=0: out returns the written data next cycle.
- A request arriving in the RESP cycle is accepted, so responses may be back-to-back.
- out holds its last value when outValid=0.

Test Plan:
- Reset sequencing: hold reset=0 for 3 cycles, then release. Required: out=0, outValid=0, busy=0, addrErr=0. Write 0xDEADBEEF @0x10, then read @0x10 with WAIT_CYCLES=1. Required: busy=1 for 1 cycle, outValid pulses 2 clocks after accept with out=0xDEADBEEF.
- Write-first forwarding: WAIT_CYCLES=2. Read @0x20 (holding 0x11111111) and, in the last WAIT cycle, write 0x22222222 @0x20. Required: response out=0x22222222.
- Ignored requests and back-to-back: WAIT_CYCLES=2, readEnabled held high for 6 cycles at addresses 0x0,0x4,0x8,... Required: only requests sampled with busy=0 are answered, outValid every 3 cycles, no extra responses. With WAIT_CYCLES=0 and reads of 0x0,0x4,0x8 on consecutive cycles: 3 consecutive outValid pulses with the matching data.
- Address errors: write 0xAAAA5555 @0x3FC, then read @0x3FE. Required: addrErr=1 and out=0xAAAA5555. Write @0x400 (ADDR_W=8). Required: discarded, addrErr stays 1. Read @0x400. Required: out=0.
- Reset mid-read: WAIT_CYCLES=3, read accepted, then reset=0 asserted during the second WAIT cycle. Required: busy=0 and outValid=0 immediately (asynchronous), and no response after release.
- Concurrent write while busy: during WAIT, writeEnabled=1 @0x40 with 0x12345678. Required: the write lands despite busy=1. A later read @0x40 returns 0x12345678.
